// File: rtl/fifo_bundle_unpacker_pkg.sv
// ---------------------------------------------------------------------------
// fifo_bundle_unpacker_pkg
// Shared constants for the bundle unpacker that sits on the read side of the
// 362-bit FWFT bundle FIFO.
//   LANES          lanes per bundle
//   LANE_W         bits per lane, including the lane valid bit (MSB of lane)
//   IDX_W          lane index width, $clog2(LANES) with a floor of 1
//   PTR_W          lane pointer width; one extra bit so ptr can reach LANES
//   BUNDLE_W       FIFO word width, LANES*LANE_W
//   LANE_VALID_BIT bit position of the valid flag inside one lane
//   PAYLOAD_W      payload width of one lane once the valid bit is stripped
// ---------------------------------------------------------------------------
package fifo_bundle_unpacker_pkg;

    localparam int unsigned LANES          = 2;
    localparam int unsigned LANE_W         = 181;
    localparam int unsigned IDX_W          = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PTR_W          = IDX_W + 1;
    localparam int unsigned BUNDLE_W       = LANES * LANE_W;
    localparam int unsigned LANE_VALID_BIT = LANE_W - 1;
    localparam int unsigned PAYLOAD_W      = LANE_W - 1;

    // Lane k of a bundle occupies bundle[k*LANE_W +: LANE_W].
    function automatic logic [LANE_W-1:0] lane_of(
        input logic [BUNDLE_W-1:0] bundle,
        input int unsigned         k
    );
        return bundle[k*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/fifo_bundle_unpacker_lane_next_sel.sv
// ---------------------------------------------------------------------------
// lane_next_sel
// Combinational priority encoder that picks the next lane to emit.
//   lane_valid   per-lane valid bits of the head bundle
//   ptr          next lane to examine (0..LANES); LANES means nothing left
//   sel_found    some valid lane exists at or above ptr
//   sel_idx      lowest such lane (0 when sel_found is 0)
//   sel_is_last  no valid lane exists above sel_idx
// ---------------------------------------------------------------------------
module lane_next_sel
    import fifo_bundle_unpacker_pkg::*;
(
    input  logic [LANES-1:0] lane_valid,
    input  logic [PTR_W-1:0] ptr,
    output logic             sel_found,
    output logic [IDX_W-1:0] sel_idx,
    output logic             sel_is_last
);

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        // Scan downwards so the lowest qualifying lane wins.
        for (int unsigned k = LANES; k > 0; k--) begin
            if (lane_valid[k-1] && ((k - 1) >= 32'(ptr))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k - 1);
            end
        end
    end

    // Any valid lane above sel is necessarily also at or above ptr, so the
    // unmasked valid bits are sufficient here.
    always_comb begin
        sel_is_last = sel_found;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (lane_valid[k] && (k > 32'(sel_idx))) begin
                sel_is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fifo_bundle_unpacker.sv
// ---------------------------------------------------------------------------
// fifo_bundle_unpacker
// Read-side consumer of the FWFT bundle FIFO. Emits the valid lanes of the
// head bundle one per cycle, lowest lane first, on a registered valid/ready
// stream, and pops the FIFO when the last valid lane is loaded.
//   i_clk         clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_flush       synchronous flush: drop output, restart head at lane 0
//   i_fifo_data   FWFT head bundle
//   i_fifo_empty  head invalid when 1
//   o_fifo_r_en   pop head bundle (combinational)
//   o_valid       output lane valid (registered)
//   o_data        lane payload with the valid bit stripped (registered)
//   o_lane_idx    source lane number of o_data (registered)
//   o_last        o_data is the last valid lane of its bundle (registered)
//   i_ready       downstream accepts when o_valid && i_ready
// ---------------------------------------------------------------------------
module fifo_bundle_unpacker
    import fifo_bundle_unpacker_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic [BUNDLE_W-1:0] i_fifo_data,
    input  logic                i_fifo_empty,
    output logic                o_fifo_r_en,
    output logic                o_valid,
    output logic [LANE_W-2:0]   o_data,
    output logic [IDX_W-1:0]    o_lane_idx,
    output logic                o_last,
    input  logic                i_ready
);

    logic [LANE_W-1:0] lanes [LANES];
    logic [LANES-1:0]  lane_valid;
    logic [PTR_W-1:0]  ptr;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_is_last;
    logic [LANE_W-1:0] sel_lane;
    logic              load_ok;
    logic              advance;

    always_comb begin
        lanes      = '{default: '0};
        lane_valid = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lanes[k]      = lane_of(i_fifo_data, k);
            lane_valid[k] = lanes[k][LANE_VALID_BIT];
        end
    end

    lane_next_sel u_lane_next_sel (
        .lane_valid  (lane_valid),
        .ptr         (ptr),
        .sel_found   (sel_found),
        .sel_idx     (sel_idx),
        .sel_is_last (sel_is_last)
    );

    assign sel_lane = lanes[sel_idx];

    // The output register can take a new lane when it is empty or draining.
    assign load_ok = !o_valid || i_ready;
    assign advance = !i_fifo_empty && load_ok && !i_flush;

    // Pop once the last valid lane is loaded, or immediately when nothing
    // valid remains at or above ptr (all-invalid bundle included).
    assign o_fifo_r_en = !i_rst && advance && (!sel_found || sel_is_last);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr        <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_lane_idx <= '0;
            o_last     <= 1'b0;
        end else if (i_flush) begin
            ptr     <= '0;
            o_valid <= 1'b0;
        end else if (load_ok) begin
            if (i_fifo_empty) begin
                o_valid <= 1'b0;
            end else if (sel_found) begin
                o_valid    <= 1'b1;
                o_data     <= sel_lane[PAYLOAD_W-1:0];
                o_lane_idx <= sel_idx;
                o_last     <= sel_is_last;
                ptr        <= sel_is_last ? '0 : ({1'b0, sel_idx} + PTR_W'(1));
            end else begin
                o_valid <= 1'b0;
                ptr     <= '0;
            end
        end
    end

endmodule
